// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory multi-cycle MIPS datapath.
// One control word per state, ready handshake on memory states, retired-instruction counter.
module multicycle_controller #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic [3:0]             state,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   pc_en,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC += 4 when memory completes
  // DECODE   | read registers, precompute branch target
  // MEM_ADDR | compute lw/sw effective address
  // MEM_RD   | data read, wait for mem_ready
  // MEM_WB   | write MDR to rt, retire
  // MEM_WR   | data write, wait for mem_ready, retire
  // EXEC     | R-type ALU operation
  // R_WB     | write ALUOut to rd, retire
  // BRANCH   | beq compare and conditional PC write, retire
  // JUMP     | PC <= jump target, retire
  // ADDI_EX  | rs + sext imm
  // ADDI_WB  | write ALUOut to rt, retire
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   retire;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEM_WR:                                      retire = mem_ready;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
      default:                                       retire = 1'b0;
    endcase
    cnt_d = retire ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     state_q <= S_EXEC;
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDI_EX;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: state_q <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_EXEC:     state_q <= S_R_WB;
        S_ADDI_EX:  state_q <= S_ADDI_WB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  logic pcw_c, irw_c, mr_c, mw_c, rw_c, ill_c;

  always_comb begin
    pcw_c = 1'b0; irw_c = 1'b0; mr_c = 1'b0; mw_c = 1'b0; rw_c = 1'b0; ill_c = 1'b0;
    pc_write_cond = 1'b0; i_or_d = 1'b0; mem_to_reg = 1'b0; reg_dst = 1'b0;
    alu_src_a = 1'b0; alu_src_b = 2'b00; alu_op = 2'b00; pc_source = 2'b00;
    case (state_q)
      S_FETCH: begin
        mr_c = 1'b1; alu_src_b = 2'b01;
        irw_c = mem_ready; pcw_c = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ill_c = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_RD:   begin mr_c = 1'b1; i_or_d = 1'b1; end
      S_MEM_WB:   begin rw_c = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WR:   begin mw_c = 1'b1; i_or_d = 1'b1; end
      S_EXEC:     begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_R_WB:     begin rw_c = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_op = 2'b01;
        pc_write_cond = 1'b1; pc_source = 2'b01;
      end
      S_JUMP:     begin pcw_c = 1'b1; pc_source = 2'b10; end
      S_ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDI_WB:  rw_c = 1'b1;
      default: ;
    endcase
  end

  // Enables are gated combinationally so nothing fires during reset, even mid-instruction.
  assign pc_write    = rst & pcw_c;
  assign pc_en       = rst & (pcw_c | (pc_write_cond & zero));
  assign ir_write    = rst & irw_c;
  assign mem_read    = rst & mr_c;
  assign mem_write   = rst & mw_c;
  assign reg_write   = rst & rw_c;
  assign illegal     = rst & ill_c;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words are
// queued as stimulus is driven and compared against the DUT at the falling edge.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;

  logic [3:0]  state;
  logic        pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] instr_count;

  logic [3:0]  w_state;
  logic        w_pc_write, w_pc_write_cond, w_pc_en, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic        w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_illegal;
  logic [1:0]  w_alu_src_b, w_alu_op, w_pc_source;
  logic [1:0]  w_instr_count;

  always #5 clk = ~clk;

  multicycle_controller #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal(illegal), .instr_count(instr_count)
  );

  // Narrow counter instance so that wrap-around is reachable in a few instructions.
  multicycle_controller #(.COUNT_WIDTH(2)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(w_state), .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .pc_en(w_pc_en),
    .i_or_d(w_i_or_d), .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
    .mem_to_reg(w_mem_to_reg), .reg_dst(w_reg_dst), .reg_write(w_reg_write),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .pc_source(w_pc_source),
    .illegal(w_illegal), .instr_count(w_instr_count)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcc, pce, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       ill;
  } ctl_t;

  ctl_t sb[$];
  ctl_t e, o;
  int   checks = 0;
  int   passed = 0;
  int   exp_cnt = 0;

  function automatic ctl_t model(logic [3:0] st, logic [5:0] op, logic z, logic rdy, logic rn);
    ctl_t c = '0;
    c.st = st;
    case (st)
      4'd0:  begin c.mr = 1; c.asb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      4'd1:  begin
        c.asb = 2'b11;
        c.ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
      end
      4'd2:  begin c.asa = 1; c.asb = 2'b10; end
      4'd3:  begin c.mr = 1; c.iord = 1; end
      4'd4:  begin c.rw = 1; c.m2r = 1; end
      4'd5:  begin c.mw = 1; c.iord = 1; end
      4'd6:  begin c.asa = 1; c.aop = 2'b10; end
      4'd7:  begin c.rw = 1; c.rdst = 1; end
      4'd8:  begin c.asa = 1; c.aop = 2'b01; c.pcc = 1; c.psrc = 2'b01; end
      4'd9:  begin c.pcw = 1; c.psrc = 2'b10; end
      4'd10: begin c.asa = 1; c.asb = 2'b10; end
      4'd11: c.rw = 1;
      default: ;
    endcase
    c.pce = c.pcw | (c.pcc & z);
    if (!rn) begin
      c.pcw = 0; c.pce = 0; c.irw = 0; c.mr = 0; c.mw = 0; c.rw = 0; c.ill = 0;
    end
    return c;
  endfunction

  function automatic ctl_t obs();
    ctl_t c;
    c.st = state; c.pcw = pc_write; c.pcc = pc_write_cond; c.pce = pc_en; c.iord = i_or_d;
    c.mr = mem_read; c.mw = mem_write; c.irw = ir_write; c.m2r = mem_to_reg; c.rdst = reg_dst;
    c.rw = reg_write; c.asa = alu_src_a; c.asb = alu_src_b; c.aop = alu_op; c.psrc = pc_source;
    c.ill = illegal;
    return c;
  endfunction

  // Stimulus side: apply inputs for one cycle, queue what the DUT must show, move to the sample point.
  task automatic drive(input logic [5:0] op, input logic z, input logic rdy, input logic [3:0] est);
    opcode = op; zero = z; mem_ready = rdy;
    sb.push_back(model(est, op, z, rdy, rst));
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0; mem_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    drive(6'd0, 1'b0, 1'b1, 4'd0);
    e = sb.pop_front(); o = obs();
    checks++; if (o !== e) $display("FAIL reset_ctl actual=%h required=%h", o, e); else passed++;
    checks++; if (instr_count !== 32'd0) $display("FAIL reset_cnt actual=%0d required=0", instr_count); else passed++;
    rst = 1;
    sb.push_back(model(4'd0, 6'd0, 1'b0, 1'b1, 1'b1));
    #1;
    e = sb.pop_front(); o = obs();
    checks++; if (o !== e) $display("FAIL release_fetch actual=%h required=%h", o, e); else passed++;
    mem_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_instr(input string name, input logic [5:0] op, input logic z,
                            input logic [3:0] sts[$], input logic rdys[$], input bit retires);
    for (int i = 0; i < sts.size(); i++) begin
      drive(op, z, rdys[i], sts[i]);
      e = sb.pop_front(); o = obs();
      checks++;
      if (o !== e) $display("FAIL %s cyc%0d actual=%h required=%h", name, i, o, e);
      else passed++;
      @(posedge clk); #1;
    end
    if (retires) exp_cnt++;
    checks++;
    if (instr_count !== 32'(exp_cnt))
      $display("FAIL %s_count actual=%0d required=%0d", name, instr_count, exp_cnt);
    else passed++;
    mem_ready = 0;
  endtask

  task automatic test_rtype();   test_instr("rtype", 6'b000000, 0, '{0,1,6,7}, '{1,1,1,1}, 1); endtask
  task automatic test_lw();      test_instr("lw", 6'b100011, 0, '{0,1,2,3,3,3,3,4}, '{1,1,1,0,0,0,1,1}, 1); endtask
  task automatic test_sw();      test_instr("sw", 6'b101011, 0, '{0,1,2,5,5}, '{1,1,1,0,1}, 1); endtask
  task automatic test_beq();
    test_instr("beq_z1", 6'b000100, 1, '{0,1,8}, '{1,1,1}, 1);
    test_instr("beq_z0", 6'b000100, 0, '{0,1,8}, '{1,1,1}, 1);
  endtask
  task automatic test_illegal(); test_instr("illegal", 6'b111111, 0, '{0,1,0}, '{1,1,0}, 0); endtask
  task automatic test_jump();    test_instr("jump", 6'b000010, 0, '{0,1,9}, '{1,1,1}, 1); endtask
  task automatic test_back_to_back();
    test_instr("b2b_addi", 6'b001000, 0, '{0,1,10,11}, '{1,1,1,1}, 1);
    test_instr("b2b_rtype", 6'b000000, 0, '{0,1,6,7}, '{1,1,1,1}, 1);
  endtask

  task automatic test_reset_midwrite();
    logic [3:0] sts[$] = '{0,1,2,5};
    logic       rdys[$] = '{1,1,1,0};
    for (int i = 0; i < sts.size(); i++) begin
      drive(6'b101011, 1'b0, rdys[i], sts[i]);
      e = sb.pop_front(); o = obs();
      checks++; if (o !== e) $display("FAIL midwr cyc%0d actual=%h required=%h", i, o, e); else passed++;
      if (i < sts.size() - 1) begin @(posedge clk); #1; end
    end
    rst = 0;
    @(posedge clk); #1;
    sb.push_back(model(4'd0, 6'b101011, 1'b0, 1'b0, 1'b0));
    exp_cnt = 0;
    e = sb.pop_front(); o = obs();
    checks++; if (o !== e) $display("FAIL midwr_reset actual=%h required=%h", o, e); else passed++;
    checks++; if (instr_count !== 32'd0) $display("FAIL midwr_cnt actual=%0d required=0", instr_count); else passed++;
    checks++; if (w_instr_count !== 2'd0) $display("FAIL midwr_wcnt actual=%0d required=0", w_instr_count); else passed++;
    rst = 1; mem_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 5; k++) begin
      test_instr("wrap_j", 6'b000010, 0, '{0,1,9}, '{1,1,1}, 1);
      checks++;
      if (w_instr_count !== 2'(exp_cnt))
        $display("FAIL wrap_cnt%0d actual=%0d required=%0d", k, w_instr_count, 2'(exp_cnt));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_jump();
    test_back_to_back();
    test_reset_midwrite();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a shared-memory multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, and IR/MDR/A/B/ALUOut holding registers.
- Replaces the single-cycle decoder with per-state control words.
- Handles variable-latency memory through a ready handshake.
- Counts retired instructions.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-low (0 = reset).
opcode  input  6  IR[31:26].
zero  input  1  ALU zero flag.
mem_ready  input  1  memory completes the current access this cycle.
state  output  4  current state encoding.
pc_write  output  1  unconditional PC write.
pc_write_cond  output  1  conditional PC write (beq).
pc_en  output  1  pc_write | (pc_write_cond & zero).
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
ir_write  output  1  load IR.
mem_to_reg  output  1  write-back select: 1 = MDR.
reg_dst  output  1  destination register select: 1 = rd, 0 = rt.
reg_write  output  1  register file write enable.
alu_src_a  output  1  ALU A select: 0 = PC, 1 = A.
alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2.
alu_op  output  2  00 = add, 01 = sub, 10 = funct.
pc_source  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
illegal  output  1  unsupported opcode seen in DECODE.
instr_count  output  COUNT_WIDTH  retired instruction count.

Behaviour:
- Reset:
  - rst=0 at a rising edge sets state=FETCH(0) and instr_count=0.
  - While rst=0, pc_write, pc_en, ir_write, mem_read, mem_write, reg_write and illegal are forced 0.
  - Reset mid-instruction abandons the instruction without counting it.
- States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11. Codes 12–15 go to FETCH on the next edge with all enables 0.
- Default output value is 0 unless listed below.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are 1 only when mem_ready=1 (Mealy).
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 000000→EXEC; 100011 or 101011→MEM_ADDR; 000100→BRANCH; 000010→JUMP; 001000→ADDI_EX.
  - Any other opcode→FETCH with illegal=1 for this cycle only; the instruction is not counted.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for opcode 100011, MEM_WR for 101011.
- MEM_RD: mem_read=1, i_or_d=1. Wait while mem_ready=0, then go to MEM_WB.
- MEM_WR: mem_write=1, i_or_d=1. Wait while mem_ready=0, then go to FETCH and retire.
- mem_read/mem_write stay asserted and stable for every wait cycle. ready=1 in the first cycle gives zero wait states.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH and retire.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH and retire.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - pc_en=zero. Go to FETCH and retire.
- JUMP: pc_write=1, pc_source=10. Go to FETCH and retire.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH and retire.
- Retire: instr_count increments by 1 on the edge that leaves a retiring state. The counter wraps modulo 2^COUNT_WIDTH.
- opcode is sampled only in DECODE and MEM_ADDR. The IR is stable after FETCH, so no input latching is needed.
- Cycle counts with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- mem_write and mem_read are never both 1 in the same cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_ready=1 → state=0, instr_count=0, all enables 0. Release → FETCH drives mem_read=1, ir_write=1, pc_write=1.
- R-type, opcode 000000, mem_ready=1 → state sequence 0,1,6,7,0. reg_write=1 with reg_dst=1 only in state 7. instr_count=1 after 4 cycles.
- lw (100011) with 3 wait cycles in MEM_RD → state sequence 0,1,2,3,3,3,3,4,0. mem_read held for 4 cycles. instr_count +1.
- sw (101011) then beq (000100), zero=1 and zero=0 → sw: mem_write=1 in state 5 only, reg_write never 1. beq: pc_en=1 with zero=1, 0 with zero=0. Both retire.
- Illegal opcode 111111 → DECODE pulses illegal=1 for one cycle, returns to FETCH, instr_count unchanged. j (000010) → pc_write=1 with pc_source=10 in state 9.
- Assert rst=0 during a MEM_WR wait (mem_ready=0) → next edge state=0, mem_write=0, instr_count=0. Separately, preload instr_count=2^32−1 via stimulus and retire one instruction → wraps to 0.
